// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS datapath: default word width and
// the state encoding of the registered operand-select stage.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational CHANNELS:1 selector; an index past the last channel yields
// all-zero data and drops o_in_range.
module mux_n_comb #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]          i_sel,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_in_range
);

    // One extra bit so CHANNELS itself is representable when it is a power of 2.
    logic [SEL_W:0] w_sel_ext;

    assign w_sel_ext  = {1'b0, i_sel};
    assign o_in_range = (w_sel_ext < (SEL_W+1)'(CHANNELS));

    always_comb begin
        o_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_sel_ext == (SEL_W+1)'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N-channel operand selector with one registered output stage and a two-entry
// skid store (output register + skid register) for full-rate valid/ready flow.
module mux_n_pipe
    import mips_pkg::*;
#(
    parameter  int WIDTH    = WORD_W,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err,
    input  logic                      err_clear,
    output logic [1:0]                dbg_state
);

    // Handshake: a beat transfers on a rising edge where valid & ready are both
    // high; once valid is raised the sender holds its payload until transfer.
    // in_ready and out_valid come from r_state only, so out_ready never reaches
    // in_ready combinationally.

    pipe_state_t            r_state;
    pipe_state_t            w_state_nxt;
    logic [WIDTH-1:0]       r_out_data;
    logic [SEL_W-1:0]       r_out_sel;
    logic [WIDTH-1:0]       r_skid_data;
    logic [SEL_W-1:0]       r_skid_sel;
    logic                   r_sel_err;

    logic [WIDTH-1:0]       w_sel_data;
    logic                   w_in_range;
    logic                   w_accept;
    logic                   w_load_out_in;
    logic                   w_load_out_skid;
    logic                   w_load_skid;

    mux_n_comb #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_mux (
        .i_data     (in_data),
        .i_sel      (sel),
        .o_data     (w_sel_data),
        .o_in_range (w_in_range)
    );

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign sel_err   = r_sel_err;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && out_ready) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_sel  <= '0;
        end else if (w_load_out_in) begin
            r_out_data <= w_sel_data;
            r_out_sel  <= sel;
        end else if (w_load_out_skid) begin
            r_out_data <= r_skid_data;
            r_out_sel  <= r_skid_sel;
        end
    end

    // The skid holds already-selected data, so a single mux serves both paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_data <= '0;
            r_skid_sel  <= '0;
        end else if (w_load_skid) begin
            r_skid_data <= w_sel_data;
            r_skid_sel  <= sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            r_sel_err <= 1'b1;
        end else if (err_clear) begin
            r_sel_err <= 1'b0;
        end
    end

endmodule

// File: doc/mux_n_pipe.md
Name: mux_n_pipe

Overview:
- Parametrised N-channel, WIDTH-bit operand selector with one registered stage and a valid/ready handshake.
- Successor to the combinational 2-channel 32-bit select used in the datapath.
- Used in the pipelined MIPS datapath for register-address, ALU-operand and forwarding selection, where a select must cross a stage boundary without losing data under stall.
- A two-entry skid store gives full throughput: one beat per cycle while out_ready is held high.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- CHANNELS, 4, number of input channels; must be 2 or more.
- SEL_W, derived localparam $clog2(CHANNELS), width of sel; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_data  in  CHANNELS*WIDTH  flattened channels; channel k is in_data[k*WIDTH +: WIDTH].
- sel  in  SEL_W  channel index, sampled with the beat.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  registered index that produced out_data.
- out_valid  out  1  out_data/out_sel valid.
- out_ready  in  1  downstream accepts.
- sel_err  out  1  sticky out-of-range select flag.
- err_clear  in  1  synchronous clear of sel_err.

Behaviour:
- Accept = in_valid & in_ready. Fire = out_valid & out_ready.
- The beat is captured on the clock edge at accept; it appears on out_data one cycle later when the output stage is empty or firing. Latency is 1 cycle.
- State register has three states: EMPTY, ONE (output holds a beat, skid empty) and FULL (output and skid both hold beats).
- out_valid = (state != EMPTY). in_ready = (state != FULL). Both are decoded from registers only; there is no combinational path from out_ready to in_ready.
- EMPTY:
  - accept -> ONE; the output register loads the selected input.
- ONE:
  - accept & out_ready -> ONE; the output register reloads from the input.
  - accept & !out_ready -> FULL; the beat goes to skid.
  - !accept & out_ready -> EMPTY.
  - Otherwise hold.
- FULL (in_ready = 0):
  - out_ready -> ONE; the output register loads from skid.
  - Otherwise hold.
- Output and skid contents change only on a load. While out_valid & !out_ready, out_data and out_sel are stable.
- Beat ordering is strictly preserved.
- Selection is sel < CHANNELS ? channel[sel] : all zeros. This matters only when CHANNELS is not a power of 2.
- sel_err:
  - Set on the edge of any accept with sel >= CHANNELS.
  - Cleared on the edge when err_clear = 1.
  - Set wins over simultaneous clear.
  - The out-of-range beat is still passed downstream as zero data, with out_sel = the raw sel value.
- in_valid asserted while in_ready = 0 has no effect. Upstream must hold in_data and sel until accept.
- Reset (rst_n low, any time including mid-transfer):
  - State goes to EMPTY; out_valid = 0, in_ready = 1.
  - out_data = 0, out_sel = 0, skid contents = 0, sel_err = 0.
  - Any beats in flight are discarded.
  - Accepts are ignored while rst_n is low. Normal operation starts on the first rising clk edge after rst_n rises.

Decomposition:
- Shared package mips_pkg holds:
  - localparams for state encoding: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - the default datapath width WORD_W=32.
- One sub-module is natural: mux_n_comb. It is the purely combinational CHANNELS:1 selector with the zero-on-out-of-range rule, parameters WIDTH and CHANNELS.
- mux_n_comb is instantiated once on the input path. The skid store uses the already-selected data, so no second mux is needed.

Test Plan:
- Reset and idle:
  - Stimulus: rst_n low 3 cycles, then high; in_valid = 0.
  - Required: out_valid = 0, in_ready = 1, out_data = 0, sel_err = 0 throughout.
- Streaming:
  - Stimulus: CHANNELS=4, channel k = 32'hA000_0000+k, out_ready = 1, 8 back-to-back beats with sel = 0,1,2,3,3,2,1,0.
  - Required: out_data follows A0000000, A0000001, ..., A0000000, each 1 cycle after its accept, with no bubbles and in_ready never low.
- Stall and skid:
  - Stimulus: out_ready = 0, send beats sel=1 then sel=2.
  - Required: state FULL, in_ready = 0, out_data = A0000001 held stable.
  - Then raise out_ready for 2 cycles: out_data shows A0000001 then A0000002, in order, with nothing lost or duplicated.
- Out-of-range:
  - Stimulus: CHANNELS=3, SEL_W=2, one beat with sel = 3.
  - Required: out_data = 0, out_sel = 3, sel_err = 1 and stays set.
  - Assert err_clear together with another sel=3 accept: sel_err stays 1. Next cycle, err_clear alone gives sel_err = 0.
- Reset mid-operation:
  - Stimulus: in state FULL, pulse rst_n low asynchronously between clock edges.
  - Required: out_valid drops immediately with no clock, out_data = 0, and after release the first new beat is the first output seen.
- Randomised soak:
  - Stimulus: WIDTH=8, CHANNELS=5, random in_valid/out_ready for 10k cycles against a scoreboard.
  - Required: output sequence equals the accepted sequence, and out_data/out_sel stay stable whenever out_valid & !out_ready.
